// File: rtl/div_sequencer.sv
// Purpose: sequences the signed/unsigned divider IP cores for the execute stage; one divide in flight.
// Latency: tvalids one cycle after acceptance; res_valid one cycle after the IP result pulse; IDLE one cycle after res_ack.
// Backpressure: req_ready only in IDLE; operand tvalids held until tready; result held until res_ack.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (req_signed, req_dividend, req_divisor)
//   flush                           cancels the operation in flight; a cancelled result is drained
//   res_valid/res_ack               result handshake (res_quo, res_rem)
//   busy                            sequencer not in IDLE
//   dvd_tdata/dvs_tdata             latched operands shared by both cores
//   {sdiv,udiv}_{dvd,dvs}_tvalid/tready   operand AXI-stream channels per core
//   {sdiv,udiv}_dout_tvalid/tdata   one-cycle result pulse per core
module div_sequencer (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,

    input  logic        flush,

    output logic        res_valid,
    output logic [31:0] res_quo,
    output logic [31:0] res_rem,
    input  logic        res_ack,

    output logic        busy,

    output logic [31:0] dvd_tdata,
    output logic [31:0] dvs_tdata,

    output logic        sdiv_dvd_tvalid,
    output logic        sdiv_dvs_tvalid,
    output logic        udiv_dvd_tvalid,
    output logic        udiv_dvs_tvalid,
    input  logic        sdiv_dvd_tready,
    input  logic        sdiv_dvs_tready,
    input  logic        udiv_dvd_tready,
    input  logic        udiv_dvs_tready,

    input  logic        sdiv_dout_tvalid,
    input  logic [63:0] sdiv_dout_tdata,
    input  logic        udiv_dout_tvalid,
    input  logic [63:0] udiv_dout_tdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state_q,      state_d;
    logic        sel_signed_q, sel_signed_d;
    logic [31:0] dvd_q,        dvd_d;
    logic [31:0] dvs_q,        dvs_d;
    logic        dvd_pend_q,   dvd_pend_d;
    logic        dvs_pend_q,   dvs_pend_d;
    logic        cancel_q,     cancel_d;
    logic [31:0] quo_q,        quo_d;
    logic [31:0] rem_q,        rem_d;

    // Channel signals of whichever core the latched request selected.
    logic        sel_dvd_tready;
    logic        sel_dvs_tready;
    logic        sel_dout_tvalid;
    logic [63:0] sel_dout_tdata;
    logic        in_send;

    assign sel_dvd_tready  = sel_signed_q ? sdiv_dvd_tready  : udiv_dvd_tready;
    assign sel_dvs_tready  = sel_signed_q ? sdiv_dvs_tready  : udiv_dvs_tready;
    assign sel_dout_tvalid = sel_signed_q ? sdiv_dout_tvalid : udiv_dout_tvalid;
    assign sel_dout_tdata  = sel_signed_q ? sdiv_dout_tdata  : udiv_dout_tdata;

    // Outputs decode from registered state only, so nothing on the request
    // side reaches a tvalid combinationally.
    assign in_send         = (state_q == ST_SEND);
    assign sdiv_dvd_tvalid = in_send &  sel_signed_q & dvd_pend_q;
    assign sdiv_dvs_tvalid = in_send &  sel_signed_q & dvs_pend_q;
    assign udiv_dvd_tvalid = in_send & ~sel_signed_q & dvd_pend_q;
    assign udiv_dvs_tvalid = in_send & ~sel_signed_q & dvs_pend_q;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_quo   = quo_q;
    assign res_rem   = rem_q;
    assign dvd_tdata = dvd_q;
    assign dvs_tdata = dvs_q;

    always_comb begin
        state_d      = state_q;
        sel_signed_d = sel_signed_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        dvd_pend_d   = dvd_pend_q;
        dvs_pend_d   = dvs_pend_q;
        cancel_d     = cancel_q;
        quo_d        = quo_q;
        rem_d        = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;
                if (req_valid && !flush) begin
                    sel_signed_d = req_signed;
                    dvd_d        = req_dividend;
                    dvs_d        = req_divisor;
                    dvd_pend_d   = 1'b1;
                    dvs_pend_d   = 1'b1;
                    state_d      = ST_SEND;
                end
            end

            ST_SEND: begin
                // A flush cannot withdraw a presented tvalid, so it is only
                // remembered here and acted on once both operands are taken.
                cancel_d   = cancel_q | flush;
                dvd_pend_d = dvd_pend_q & ~sel_dvd_tready;
                dvs_pend_d = dvs_pend_q & ~sel_dvs_tready;
                if (!dvd_pend_d && !dvs_pend_d) begin
                    state_d = cancel_d ? ST_DRAIN : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (flush) begin
                    // A result arriving with the flush is the cancelled one;
                    // with nothing left outstanding there is nothing to drain.
                    state_d = sel_dout_tvalid ? ST_IDLE : ST_DRAIN;
                end else if (sel_dout_tvalid) begin
                    quo_d   = sel_dout_tdata[63:32];
                    rem_d   = sel_dout_tdata[31:0];
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (flush || res_ack) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // The core still owes exactly one result for the cancelled op.
                if (sel_dout_tvalid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_signed_q <= 1'b0;
            dvd_q        <= 32'd0;
            dvs_q        <= 32'd0;
            dvd_pend_q   <= 1'b0;
            dvs_pend_q   <= 1'b0;
            cancel_q     <= 1'b0;
            quo_q        <= 32'd0;
            rem_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            sel_signed_q <= sel_signed_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            dvd_pend_q   <= dvd_pend_d;
            dvs_pend_q   <= dvs_pend_d;
            cancel_q     <= cancel_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Purpose: directed bench for div_sequencer; divider cores are driven by hand from the stimulus process.
// Latency: results are checked by a negedge monitor against a queue of hand-computed quotient/remainder pairs.
// Backpressure: tready delays, flushes and withheld res_ack are exercised directly.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_signed = 1'b0;
    logic [31:0] req_dividend = '0;
    logic [31:0] req_divisor = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic [31:0] res_quo;
    logic [31:0] res_rem;
    logic        res_ack = 1'b0;
    logic        busy;
    logic [31:0] dvd_tdata;
    logic [31:0] dvs_tdata;
    logic        sdiv_dvd_tvalid, sdiv_dvs_tvalid, udiv_dvd_tvalid, udiv_dvs_tvalid;
    logic        sdiv_dvd_tready = 1'b1, sdiv_dvs_tready = 1'b1;
    logic        udiv_dvd_tready = 1'b1, udiv_dvs_tready = 1'b1;
    logic        sdiv_dout_tvalid = 1'b0, udiv_dout_tvalid = 1'b0;
    logic [63:0] sdiv_dout_tdata = '0, udiv_dout_tdata = '0;

    div_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_signed       (req_signed),
        .req_dividend     (req_dividend),
        .req_divisor      (req_divisor),
        .flush            (flush),
        .res_valid        (res_valid),
        .res_quo          (res_quo),
        .res_rem          (res_rem),
        .res_ack          (res_ack),
        .busy             (busy),
        .dvd_tdata        (dvd_tdata),
        .dvs_tdata        (dvs_tdata),
        .sdiv_dvd_tvalid  (sdiv_dvd_tvalid),
        .sdiv_dvs_tvalid  (sdiv_dvs_tvalid),
        .udiv_dvd_tvalid  (udiv_dvd_tvalid),
        .udiv_dvs_tvalid  (udiv_dvs_tvalid),
        .sdiv_dvd_tready  (sdiv_dvd_tready),
        .sdiv_dvs_tready  (sdiv_dvs_tready),
        .udiv_dvd_tready  (udiv_dvd_tready),
        .udiv_dvs_tready  (udiv_dvs_tready),
        .sdiv_dout_tvalid (sdiv_dout_tvalid),
        .sdiv_dout_tdata  (sdiv_dout_tdata),
        .udiv_dout_tvalid (udiv_dout_tvalid),
        .udiv_dout_tdata  (udiv_dout_tdata)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] tvalids();
        return {sdiv_dvd_tvalid, sdiv_dvs_tvalid, udiv_dvd_tvalid, udiv_dvs_tvalid};
    endfunction

    // Presents one request for exactly one edge and checks the cycle after acceptance.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        check("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_valid    = 1'b1;
        req_signed   = s;
        req_dividend = a;
        req_divisor  = b;
        step();
        req_valid = 1'b0;
        check("tvalids_after_accept", {60'd0, tvalids()}, s ? 64'hC : 64'h3);
        check("operands_latched", {dvd_tdata, dvs_tdata}, {a, b});
        check("busy_after_accept", {62'd0, busy, req_ready}, 64'h2);
    endtask

    task automatic pulse(input logic s, input logic [63:0] d);
        if (s) begin
            sdiv_dout_tvalid = 1'b1;
            sdiv_dout_tdata  = d;
        end else begin
            udiv_dout_tvalid = 1'b1;
            udiv_dout_tdata  = d;
        end
        step();
        sdiv_dout_tvalid = 1'b0;
        udiv_dout_tvalid = 1'b0;
    endtask

    task automatic ack();
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        check("idle_after_ack", {62'd0, res_valid, req_ready}, 64'h1);
    endtask

    // Scoreboard monitor: every rising res_valid must match the oldest expected
    // result, and the value must stay put for as long as res_valid is held.
    logic        mon_prev_vld = 1'b0;
    logic [63:0] mon_held = '0;
    logic [63:0] mon_exp;
    always @(negedge clk) begin
        if (!reset) begin
            if (res_valid) begin
                if (!mon_prev_vld) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got %h expected no result", {res_quo, res_rem});
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if ({res_quo, res_rem} !== mon_exp) begin
                            errors++;
                            $display("FAIL result: got %h expected %h", {res_quo, res_rem}, mon_exp);
                        end
                    end
                    mon_held = {res_quo, res_rem};
                end else begin
                    checks++;
                    if ({res_quo, res_rem} !== mon_held) begin
                        errors++;
                        $display("FAIL result_hold: got %h expected %h", {res_quo, res_rem}, mon_held);
                    end
                end
                checks++;
                if ({req_ready, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL done_flags: got ready/busy %b expected 01", {req_ready, busy});
                end
            end
            mon_prev_vld = res_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        check("reset_flags", {61'd0, req_ready, busy, res_valid}, 64'h4);
        check("reset_tvalids", {60'd0, tvalids()}, 64'h0);
        check("reset_result", {res_quo, res_rem}, 64'h0);
        check("reset_tdata", {dvd_tdata, dvs_tdata}, 64'h0);

        // Signed -7/2, IP latency 20, held two cycles before ack.
        exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        step();
        check("s_tvalids_one_cycle", {60'd0, tvalids()}, 64'h0);
        check("s_busy_wait", {63'd0, busy}, 64'd1);
        repeat (19) step();
        pulse(1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        check("s_res_valid", {63'd0, res_valid}, 64'd1);
        repeat (2) step();
        ack();

        // Unsigned 0xFFFFFFF9/2 on the udiv core.
        exp_q.push_back({32'h7FFF_FFFC, 32'h0000_0001});
        issue(1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
        step();
        check("u_tvalids_one_cycle", {60'd0, tvalids()}, 64'h0);
        repeat (4) step();
        pulse(1'b0, {32'h7FFF_FFFC, 32'h0000_0001});
        check("u_res_valid", {63'd0, res_valid}, 64'd1);
        ack();

        // Divisor tready delayed 3 cycles; a result pulse during SEND is ignored.
        sdiv_dvs_tready = 1'b0;
        exp_q.push_back({32'hFFFF_FEB3, 32'h0000_0001});
        issue(1'b1, 32'd1000, 32'hFFFF_FFFD);
        step();
        check("dly_dvd_dropped", {60'd0, tvalids()}, 64'h4);
        sdiv_dout_tvalid = 1'b1;
        sdiv_dout_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        sdiv_dout_tvalid = 1'b0;
        check("dly_dvs_held_2", {60'd0, tvalids()}, 64'h4);
        step();
        check("dly_dvs_held_3", {60'd0, tvalids()}, 64'h4);
        check("dly_dvs_tdata_stable", {32'd0, dvs_tdata}, 64'hFFFF_FFFD);
        sdiv_dvs_tready = 1'b1;
        step();
        check("dly_handshake_done", {60'd0, tvalids()}, 64'h0);
        check("dly_still_busy", {62'd0, busy, res_valid}, 64'h2);
        step();
        pulse(1'b1, {32'hFFFF_FEB3, 32'h0000_0001});
        ack();

        // Flush one cycle after acceptance with divisor tready low.
        udiv_dvs_tready = 1'b0;
        issue(1'b0, 32'd50, 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_tvalid_kept", {60'd0, tvalids()}, 64'h1);
        step();
        check("fl_tvalid_kept_2", {60'd0, tvalids()}, 64'h1);
        udiv_dvs_tready = 1'b1;
        step();
        check("fl_drain", {60'd0, tvalids()}, 64'h0);
        check("fl_drain_busy", {62'd0, busy, res_valid}, 64'h2);
        repeat (3) step();
        check("fl_drain_still_busy", {63'd0, busy}, 64'd1);
        pulse(1'b0, {32'd10, 32'd0});
        check("fl_idle_after_drain", {62'd0, busy, req_ready}, 64'h1);
        step();
        exp_q.push_back({32'd14, 32'd2});
        issue(1'b0, 32'd100, 32'd7);
        repeat (5) step();
        pulse(1'b0, {32'd14, 32'd2});
        ack();

        // Flush in WAIT coinciding with the result pulse: straight to IDLE.
        issue(1'b1, 32'd9, 32'd4);
        step();
        flush = 1'b1;
        sdiv_dout_tvalid = 1'b1;
        sdiv_dout_tdata  = {32'd2, 32'd1};
        step();
        flush = 1'b0;
        sdiv_dout_tvalid = 1'b0;
        check("wflush_idle", {61'd0, busy, req_ready, res_valid}, 64'h2);
        step();
        check("wflush_no_drain", {61'd0, busy, req_ready, res_valid}, 64'h2);

        // Flush in DONE drops the result.
        exp_q.push_back({32'd2, 32'd1});
        issue(1'b1, 32'd9, 32'd4);
        repeat (3) step();
        pulse(1'b1, {32'd2, 32'd1});
        check("dflush_res_valid", {63'd0, res_valid}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("dflush_dropped", {62'd0, res_valid, req_ready}, 64'h1);

        // Flush in IDLE refuses the request.
        req_valid    = 1'b1;
        req_signed   = 1'b1;
        req_dividend = 32'd5;
        req_divisor  = 32'd1;
        flush        = 1'b1;
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("iflush_refused", {59'd0, tvalids(), busy}, 64'h0);

        // Signed -7/2 with a spurious udiv pulse in WAIT and res_ack withheld 10 cycles.
        exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        step();
        pulse(1'b0, 64'h1234_5678_9ABC_DEF0);
        check("spurious_ignored", {62'd0, busy, res_valid}, 64'h2);
        repeat (2) step();
        pulse(1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        for (int i = 0; i < 10; i++) begin
            if (i == 4) pulse(1'b1, 64'h0BAD_0BAD_0BAD_0BAD);
            else if (i == 6) pulse(1'b0, 64'h0BAD_0BAD_0BAD_0BAD);
            else step();
        end
        check("hold_res_valid", {63'd0, res_valid}, 64'd1);
        ack();

        repeat (2) step();
        check("scoreboard_drained", {32'd0, exp_q.size()}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
